// File: rtl/pong_sound_gen.sv
// pong_sound_gen: square-wave blip and point tones for the pong game.
// Optional ROUND_JINGLE_EN adds a third point segment on round changes.
module pong_sound_gen #(
   parameter int HIT_HALF  = 28409,
   parameter int HIT_LEN   = 2500000,
   parameter int PT_HALF_A = 18939,
   parameter int PT_HALF_B = 37878,
   parameter int PT_LEN    = 3750000,
   parameter int CNT_W     = 22
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hit,
   input  logic [2:0] scoreLeft,
   input  logic [2:0] scoreRight,
   input  logic [1:0] round,
   output logic       speaker,
   output logic       busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] HIT_TONE = 3'd1;
   localparam logic [2:0] PT_A     = 3'd2;
   localparam logic [2:0] PT_B     = 3'd3;
`ifdef ROUND_JINGLE_EN
   localparam logic [2:0] PT_C     = 3'd4;
`endif

   localparam logic [CNT_W-1:0] HIT_HALF_M1  = CNT_W'(HIT_HALF - 1);
   localparam logic [CNT_W-1:0] HIT_LEN_M1   = CNT_W'(HIT_LEN - 1);
   localparam logic [CNT_W-1:0] PT_HALF_A_M1 = CNT_W'(PT_HALF_A - 1);
   localparam logic [CNT_W-1:0] PT_HALF_B_M1 = CNT_W'(PT_HALF_B - 1);
   localparam logic [CNT_W-1:0] PT_LEN_M1    = CNT_W'(PT_LEN - 1);

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic [CNT_W-1:0] dur;
   logic [CNT_W-1:0] ph;
   logic [CNT_W-1:0] half_m1;
   logic [CNT_W-1:0] len_m1;
   logic             hit_q;
   logic [2:0]       scoreLeft_q;
   logic [2:0]       scoreRight_q;
   logic             hit_rise;
   logic             score_evt;
   logic             pt_evt;

   assign hit_rise  = hit & ~hit_q;
   assign score_evt = (scoreLeft != scoreLeft_q) |
                      (scoreRight != scoreRight_q);
   assign busy      = (state != IDLE);

`ifdef ROUND_JINGLE_EN
   logic [1:0] round_q;
   logic       jingle;
   logic       round_evt;

   assign round_evt = (round != round_q);
   assign pt_evt    = score_evt | round_evt;

   // Remember whether the running point sequence is a round jingle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         round_q <= 2'd0;
         jingle  <= 1'b0;
      end else begin
         round_q <= round;
         if (pt_evt)
            jingle <= round_evt;
      end
   end
`else
   logic unused_round;

   assign unused_round = ^round;
   assign pt_evt       = score_evt;
`endif

   // Select half-period, duration and successor of the current tone state
   always_comb begin
      half_m1    = HIT_HALF_M1;
      len_m1     = HIT_LEN_M1;
      next_state = IDLE;
      case (state)
         PT_A: begin
            half_m1    = PT_HALF_A_M1;
            len_m1     = PT_LEN_M1;
            next_state = PT_B;
         end
         PT_B: begin
            half_m1    = PT_HALF_B_M1;
            len_m1     = PT_LEN_M1;
`ifdef ROUND_JINGLE_EN
            next_state = jingle ? PT_C : IDLE;
`endif
         end
`ifdef ROUND_JINGLE_EN
         PT_C: begin
            half_m1 = PT_HALF_A_M1;
            len_m1  = PT_LEN_M1;
         end
`endif
         default: ;
      endcase
   end

   // Edge detection, state progression and square-wave generation
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         dur          <= '0;
         ph           <= '0;
         speaker      <= 1'b0;
         hit_q        <= 1'b0;
         scoreLeft_q  <= 3'd0;
         scoreRight_q <= 3'd0;
      end else begin
         hit_q        <= hit;
         scoreLeft_q  <= scoreLeft;
         scoreRight_q <= scoreRight;
         if (pt_evt) begin
            state   <= PT_A;
            dur     <= '0;
            ph      <= '0;
            speaker <= 1'b0;
         end else if (hit_rise &&
                      (state == IDLE || state == HIT_TONE)) begin
            state   <= HIT_TONE;
            dur     <= '0;
            ph      <= '0;
            speaker <= 1'b0;
         end else if (state == IDLE) begin
            dur     <= '0;
            ph      <= '0;
            speaker <= 1'b0;
         end else if (dur == len_m1) begin
            state   <= next_state;
            dur     <= '0;
            ph      <= '0;
            speaker <= 1'b0;
         end else begin
            dur <= dur + CNT_W'(1);
            if (ph == half_m1) begin
               ph      <= '0;
               speaker <= ~speaker;
            end else begin
               ph <= ph + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/pong_sound_gen.md
Name: pong_sound_gen

Overview:
- Audio back end for the pong game logic; consumes the paddle/ball controller's `hit` level and the `scoreLeft`/`scoreRight` counters.
- Drives a single-bit square-wave speaker output.
- A rising edge on `hit` plays a short blip. Any score change plays a two-segment "point" tone, which has priority over the blip.
- Sits beside the video path on the 25 MHz pixel clock domain.

Parameters:
- HIT_HALF, 28409, half-period in clocks of the hit tone (440 Hz at 25 MHz)
- HIT_LEN, 2500000, hit tone duration in clocks (100 ms)
- PT_HALF_A, 18939, half-period of point segment A (660 Hz)
- PT_HALF_B, 37878, half-period of point segment B (330 Hz)
- PT_LEN, 3750000, duration of each point segment in clocks (150 ms)
- CNT_W, 22, width of the duration and phase counters; all HALF/LEN values must be at least 1 and at most 2^CNT_W

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- hit  in  1  paddle-hit level from game logic, synchronous to clock
- scoreLeft  in  3  left score, synchronous to clock
- scoreRight  in  3  right score, synchronous to clock
- round  in  2  round counter; used only with ROUND_JINGLE_EN
- speaker  out  1  square-wave audio
- busy  out  1  high while any tone is playing

Behaviour:
- Clock and reset: single clock `clock`; asynchronous active-high reset `reset`.
- Reset values: state=IDLE, speaker=0, busy=0, hit_q=0, scoreLeft_q=0, scoreRight_q=0, round_q=0, all counters 0. Reset mid-tone aborts immediately; speaker goes low asynchronously.
- Edge detection, evaluated every clock:
  - hit_rise = hit & ~hit_q.
  - score_evt = (scoreLeft != scoreLeft_q) | (scoreRight != scoreRight_q).
  - A 7->0 wrap, or both scores clearing at once, counts as exactly one event.
  - The _q registers update every clock.
- States: IDLE, HIT_TONE, PT_A, PT_B (plus PT_C with the optional feature).
- Priority at each edge, highest first:
  1. score_evt in any state: go to PT_A with counters restarted.
  2. hit_rise in IDLE or HIT_TONE: go to HIT_TONE with counters restarted. hit_rise in PT_A/PT_B/PT_C is discarded; it is not queued.
  3. Otherwise, the normal progression below.
- Restart means: dur=0, ph=0, speaker=0, registered on the same edge.
- Latency: busy=1 on the edge where the event is first seen, i.e. visible one cycle after the input changes. No event is lost if the input changes on the first cycle after reset.
- Tone generation, in tone states only:
  - ph increments each clock.
  - When ph == HALF-1 (HALF being the current state's half-period): ph<=0 and speaker toggles.
  - So speaker first rises HALF clocks after entry.
- Duration:
  - dur increments each clock.
  - When dur == LEN-1: HIT_TONE->IDLE, PT_A->PT_B (restart counters), PT_B->IDLE.
  - On reaching IDLE, speaker=0 and busy=0 on that same edge.
- A tone state lasts exactly LEN clocks unless preempted.
- A hit level held high across several frames produces only one blip. It must fall and rise again to retrigger.
- IDLE: speaker held 0, counters held 0.
- Arithmetic: counters are unsigned CNT_W bits. Comparisons use the parameter value minus 1, computed at elaboration. No wrap can occur given the parameter constraint.

Optional Feature:
- Macro: ROUND_JINGLE_EN.
- Defined:
  - round_evt = (round != round_q).
  - round_evt takes top priority and enters PT_A, with PT_B->PT_C (PT_HALF_A, PT_LEN) added before IDLE.
  - A round change concurrent with a score change plays the 3-segment jingle once.
  - A score-only event still ends after PT_B.
- Undefined:
  - round is ignored and round_q is not built.
  - Behaviour is exactly the 4-state machine above.

Test Plan:
Bench parameters: HIT_HALF=4, HIT_LEN=40, PT_HALF_A=3, PT_HALF_B=6, PT_LEN=30.
1. Reset released, hit pulses high for 100 clocks -> busy high for exactly 40 clocks; speaker toggles every 4 clocks (5 high, 5 low periods); only one blip; speaker=0 afterwards.
2. scoreLeft 0->1 -> busy for 60 clocks; first 30 clocks toggle every 3, next 30 toggle every 6; then IDLE.
3. hit rise at clock 10 of PT_A -> ignored; sequence still ends at clock 60; no blip follows.
4. scoreRight 2->3 at clock 20 of HIT_TONE -> immediate PT_A with speaker=0 and ph=0; total busy = 20+60 clocks.
5. Both scores 7->0 (wrap) in one cycle -> a single 60-clock point sequence.
6. reset asserted at clock 15 of PT_B -> speaker=0 and busy=0 asynchronously. With ROUND_JINGLE_EN, a round change 0->1 -> 90-clock jingle (3/6/3 half-periods).
